// File: rtl/alu_hilo_sequencer_pkg.sv
// Shared types for the HI/LO sequencer.
// Provides:
//   - the control bundle (clock + synchronous active-high reset) and its accessors;
//   - the ALU function codes;
//   - the long-op and HI/LO-user classifiers;
//   - the sequencer FSM state type.
package alu_hilo_sequencer_pkg;

   typedef struct packed {
      logic clk;
      logic rst;
   } Data_Control_T;

   function automatic logic Data_Control_Clock(input Data_Control_T c);
      return c.clk;
   endfunction

   function automatic logic Data_Control_Reset(input Data_Control_T c);
      return c.rst;
   endfunction

   // Code 4'hF is left unassigned; any such code classifies as non-HI/LO.
   typedef enum logic [3:0] {
      ALU_NONE = 4'h0,
      ALU_ADD  = 4'h1,
      ALU_NOR  = 4'h2,
      ALU_SLL  = 4'h3,
      ALU_SRA  = 4'h4,
      ALU_SRL  = 4'h5,
      ALU_XOR  = 4'h6,
      ALU_MULU = 4'h7,
      ALU_MUL  = 4'h8,
      ALU_DIVU = 4'h9,
      ALU_DIV  = 4'hA,
      ALU_MFHI = 4'hB,
      ALU_MFLO = 4'hC,
      ALU_MTHI = 4'hD,
      ALU_MTLO = 4'hE
   } Alu_Func_T;

   function automatic logic alu_is_long_op(input Alu_Func_T f);
      case (f)
         ALU_MULU, ALU_MUL, ALU_DIVU, ALU_DIV: return 1'b1;
         default:                              return 1'b0;
      endcase
   endfunction

   function automatic logic alu_is_hilo_user(input Alu_Func_T f);
      case (f)
         ALU_MFHI, ALU_MFLO, ALU_MTHI, ALU_MTLO: return 1'b1;
         default:                               return alu_is_long_op(f);
      endcase
   endfunction

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/alu_hilo_timer.sv
// Loadable down-counter for the HI/LO sequencer.
// Ports:
//   clk_i   - clock
//   rst_i   - synchronous active-high reset; clears the count
//   load_i  - load DELAY; takes priority over dec_i
//   dec_i   - decrement by one; saturates at zero
//   count_o - current count
//   zero_o  - count is zero
module alu_hilo_timer
   import alu_hilo_sequencer_pkg::*;
#(
   parameter int unsigned CNT_W = 4,
   parameter int unsigned DELAY = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] count_o,
   output logic             zero_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = CNT_W'(DELAY);
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign zero_o  = (count_q == '0);

endmodule

// File: rtl/alu_hilo_sequencer.sv
// Issue-side sequencer for the multi-cycle HI/LO unit.
//
// Launches long ops, counts their latency and stalls HI/LO users while an
// operation is in flight. It contains no datapath: the HI/LO unit is driven
// only through the start and abort pulses.
//
// Ports:
//   ctrl        - control bundle (clock, synchronous active-high reset)
//   issue_valid - instruction presented this cycle
//   func        - ALU function of the presented instruction
//   flush       - pipeline flush; aborts any in-flight operation
//   start       - launch pulse to the HI/LO unit
//   abort       - cancel pulse to the HI/LO unit
//   stall       - hold the issuing stage
//   busy        - operation in flight
//   done        - last cycle of the in-flight operation
//   remaining   - cycles left including the current one; 0 when idle
module alu_hilo_sequencer
   import alu_hilo_sequencer_pkg::*;
#(
   parameter int unsigned DELAY = 2,
   parameter int unsigned CNT_W = 4
) (
   input  Data_Control_T    ctrl,
   input  logic             issue_valid,
   input  Alu_Func_T        func,
   input  logic             flush,
   output logic             start,
   output logic             abort,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] remaining
);

   logic             clk;
   logic             rst;
   state_e           state_q;
   state_e           state_d;
   logic             load;
   logic             dec;
   logic [CNT_W-1:0] count;
   logic             zero;
   logic             last;

   assign clk  = Data_Control_Clock(ctrl);
   assign rst  = Data_Control_Reset(ctrl);
   assign last = (count == CNT_W'(1));

   alu_hilo_timer #(
      .CNT_W (CNT_W),
      .DELAY (DELAY)
   ) u_timer (
      .clk_i   (clk),
      .rst_i   (rst),
      .load_i  (load),
      .dec_i   (dec),
      .count_o (count),
      .zero_o  (zero)
   );

   always_comb begin
      state_d   = state_q;
      start     = 1'b0;
      abort     = 1'b0;
      stall     = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      remaining = '0;
      load      = 1'b0;
      dec       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (issue_valid && alu_is_long_op(func) && !flush && !rst) begin
               start   = 1'b1;
               load    = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            busy      = 1'b1;
            remaining = count;
            dec       = 1'b1;
            stall     = issue_valid && alu_is_hilo_user(func) && !rst;
            if (flush && !rst) begin
               abort   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               done = last;
               // zero only guards against a stray RUN with an empty counter
               if (last || zero) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

endmodule
